// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Provides default geometry, stage-count function and a geometry check.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SEG   = 4;

  function automatic int unsigned num_stages(
    input int unsigned w,
    input int unsigned s
  );
    return w / s;
  endfunction

  function automatic bit cfg_ok(
    input int unsigned w,
    input int unsigned s
  );
    return (s >= 1) && (s <= w) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple of full adders.
// Ports: a_seg/b_seg/ci in; s_seg, co, c_msb_in (carry into top bit) out.
module rca_segment #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           ci,
  output logic [SEG-1:0] s_seg,
  output logic           co,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  always_comb begin
    c     = '0;
    s_seg = '0;
    c[0]  = ci;
    for (int i = 0; i < SEG; i++) begin
      s_seg[i] = a_seg[i] ^ b_seg[i] ^ c[i];
      c[i+1]   = (a_seg[i] & b_seg[i])
               | (c[i] & (a_seg[i] ^ b_seg[i]));
    end
  end

  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry add/sub, one register stage per SEG-bit segment.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, sub,
//        out_valid/out_ready, sum, cout, ovf.
module pipelined_rc_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, SEG);
  localparam int unsigned LAST   = STAGES - 1;

  if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("WIDTH must be a nonzero multiple of SEG");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic             vld_q;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic             co_q;

    logic             src_v, src_c;
    logic [WIDTH-1:0] src_a, src_b, src_r;
    logic [SEG-1:0]   s_seg;
    logic             co, cmsb;

    // A stage can take new data unless it and every stage
    // downstream of it is occupied while the output stalls.
    assign vld[k]  = vld_q;
    assign load[k] = out_ready | ~(&vld[LAST:k]);

    if (k == 0) begin : g_first
      assign src_v = in_valid;
      assign src_a = a;
      assign src_b = sub ? ~b : b;
      assign src_c = sub | cin;
      assign src_r = '0;
    end else begin : g_next
      assign src_v = g_stg[k-1].vld_q;
      assign src_a = g_stg[k-1].opa_q;
      assign src_b = g_stg[k-1].opb_q;
      assign src_c = g_stg[k-1].co_q;
      assign src_r = g_stg[k-1].res_q;
    end

    rca_segment #(.SEG(SEG)) u_seg (
      .a_seg    (src_a[SEG*k +: SEG]),
      .b_seg    (src_b[SEG*k +: SEG]),
      .ci       (src_c),
      .s_seg    (s_seg),
      .co       (co),
      .c_msb_in (cmsb)
    );

    always_comb begin
      res_d                = src_r;
      res_d[SEG*k +: SEG]  = s_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        res_q <= '0;
        opa_q <= '0;
        opb_q <= '0;
        co_q  <= 1'b0;
      end else if (load[k]) begin
        vld_q <= src_v;
        if (src_v) begin
          res_q <= res_d;
          opa_q <= src_a;
          opb_q <= src_b;
          co_q  <= co;
        end
      end
    end

    if (k == LAST) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load[k] && src_v) begin
          ovf_q <= cmsb ^ co;
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = g_stg[LAST].vld_q;
  assign sum       = g_stg[LAST].res_q;
  assign cout      = g_stg[LAST].co_q;
  assign ovf       = g_stg[LAST].g_ovf.ovf_q;

endmodule
